// File: rtl/gpio_bank_if.sv
// gpio_bank_if: word-addressed IO bus between the IO decoder/core and gpio_bank.
// wadr upper bits select the channel, the low 3 bits select the register.
interface gpio_bank_if #(
  parameter int unsigned CH = 2
) ();
  localparam int unsigned AW = $clog2(CH) + 3;

  logic          sel;
  logic          rd;
  logic          wr;
  logic [AW-1:0] wadr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;

  modport master (
    output sel, rd, wr, wadr, wdata,
    input  rdata
  );

  modport slave (
    input  sel, rd, wr, wadr, wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank: CH channels of WIDTH-bit GPIO with atomic set/clear, 2-flop input
// synchronisers, per-bit rise/fall detection, sticky W1C status and one level irq.
// Optional macro GPIO_DEBOUNCE_EN adds a per-bit stability counter of DB_CYCLES
// cycles between the synchroniser and the edge detector.
// Register map (low 3 word-address bits): 0 DATA, 1 OE, 2 IE, 3 RISE, 4 FALL,
// 5 STATUS (W1C), 6 SET, 7 CLR.
module gpio_bank #(
  parameter int unsigned CH        = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  gpio_bank_if.slave            bus,
  input  logic [CH*WIDTH-1:0]   i_gp,
  output logic [CH*WIDTH-1:0]   o_gp,
  output logic [CH*WIDTH-1:0]   o_gp_oe,
  output logic                  o_irq
);

  localparam int unsigned N = CH * WIDTH;

  // Register file, one WIDTH-bit slice per channel
  logic [N-1:0] r_out;
  logic [N-1:0] r_oe;
  logic [N-1:0] r_ie;
  logic [N-1:0] r_rise;
  logic [N-1:0] r_fall;
  logic [N-1:0] r_status;
  logic         r_irq;

  // Input path
  logic [N-1:0] r_sync1;
  logic [N-1:0] r_syn;
  logic [N-1:0] r_prev;
  logic [N-1:0] w_filt;

  // Decode and next-state
  logic [31:0]      w_ch;
  logic [2:0]       w_reg;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [N-1:0]     w_out_d;
  logic [N-1:0]     w_oe_d;
  logic [N-1:0]     w_ie_d;
  logic [N-1:0]     w_rise_d;
  logic [N-1:0]     w_fall_d;
  logic [N-1:0]     w_status_d;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_evt;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_ch    = 32'(bus.wadr >> 3);
  assign w_reg   = bus.wadr[2:0];
  assign w_wr    = bus.sel & bus.wr;
  assign w_wdata = bus.wdata[WIDTH-1:0];

  // rd has no side effects; upper wdata bits are ignored
  assign w_unused = bus.rd ^ (^bus.wdata);

  // Two-flop synchroniser on the asynchronous pad inputs, plus one-cycle delayed filt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_syn   <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_gp;
      r_syn   <= r_sync1;
      r_prev  <= w_filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic [CW-1:0] r_cnt [N];
  logic [N-1:0]  r_filt;

  // Per-bit debounce: filt follows syn only after DB_CYCLES consecutive differing cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_filt <= '0;
      for (int b = 0; b < N; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < N; b++) begin
        if (r_syn[b] != r_filt[b]) begin
          if (r_cnt[b] == CW'(DB_CYCLES - 1)) begin
            r_filt[b] <= r_syn[b];
            r_cnt[b]  <= '0;
          end else begin
            r_cnt[b] <= r_cnt[b] + 1'b1;
          end
        end else begin
          r_cnt[b] <= '0;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_syn;
`endif

  // Register write decode and sticky status update
  always_comb begin
    w_out_d  = r_out;
    w_oe_d   = r_oe;
    w_ie_d   = r_ie;
    w_rise_d = r_rise;
    w_fall_d = r_fall;
    w_clr    = '0;
    w_evt    = (w_filt & ~r_prev & r_rise) | (~w_filt & r_prev & r_fall);
    for (int c = 0; c < CH; c++) begin
      if (w_wr && (w_ch == 32'(c))) begin
        case (w_reg)
          3'd0: w_out_d[c*WIDTH +: WIDTH]  = w_wdata;
          3'd1: w_oe_d[c*WIDTH +: WIDTH]   = w_wdata;
          3'd2: w_ie_d[c*WIDTH +: WIDTH]   = w_wdata;
          3'd3: w_rise_d[c*WIDTH +: WIDTH] = w_wdata;
          3'd4: w_fall_d[c*WIDTH +: WIDTH] = w_wdata;
          3'd5: w_clr[c*WIDTH +: WIDTH]    = w_wdata;
          3'd6: w_out_d[c*WIDTH +: WIDTH]  = r_out[c*WIDTH +: WIDTH] | w_wdata;
          3'd7: w_out_d[c*WIDTH +: WIDTH]  = r_out[c*WIDTH +: WIDTH] & ~w_wdata;
          default: ;
        endcase
      end
    end
    // A new event on a bit beats a W1C of that same bit
    w_status_d = (r_status & ~w_clr) | w_evt;
  end

  // Control/status registers and interrupt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out    <= '0;
      r_oe     <= '0;
      r_ie     <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_out    <= w_out_d;
      r_oe     <= w_oe_d;
      r_ie     <= w_ie_d;
      r_rise   <= w_rise_d;
      r_fall   <= w_fall_d;
      r_status <= w_status_d;
      r_irq    <= |(r_status & r_ie);
    end
  end

  // Combinational read mux; zero when unselected or channel out of range
  always_comb begin
    w_rdata = '0;
    for (int c = 0; c < CH; c++) begin
      if (bus.sel && (w_ch == 32'(c))) begin
        case (w_reg)
          3'd0:    w_rdata[WIDTH-1:0] = w_filt[c*WIDTH +: WIDTH];
          3'd1:    w_rdata[WIDTH-1:0] = r_oe[c*WIDTH +: WIDTH];
          3'd2:    w_rdata[WIDTH-1:0] = r_ie[c*WIDTH +: WIDTH];
          3'd3:    w_rdata[WIDTH-1:0] = r_rise[c*WIDTH +: WIDTH];
          3'd4:    w_rdata[WIDTH-1:0] = r_fall[c*WIDTH +: WIDTH];
          3'd5:    w_rdata[WIDTH-1:0] = r_status[c*WIDTH +: WIDTH];
          default: w_rdata[WIDTH-1:0] = r_out[c*WIDTH +: WIDTH];
        endcase
      end
    end
  end

  assign bus.rdata = w_rdata;
  assign o_gp      = r_out;
  assign o_gp_oe   = r_oe;
  assign o_irq     = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed stimulus with a scoreboard queue; the monitor pops and
// compares at the falling edge whenever a read is on the bus or a pin/irq check
// is strobed. CH=3 so that channel index 3 is addressable but out of range.
module tb_gpio_bank;

  localparam int unsigned CH    = 3;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N     = CH * WIDTH;
  localparam int unsigned AW    = $clog2(CH) + 3;
`ifdef GPIO_DEBOUNCE_EN
  localparam int Lat = 3 + 16;
`else
  localparam int Lat = 3;
`endif

  typedef struct {
    int          kind;  // 0 rdata, 1 gp_o, 2 gp_oe, 3 irq
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] gp_i  = '0;
  logic [N-1:0] gp_o;
  logic [N-1:0] gp_oe;
  logic         irq;
  logic         chk   = 1'b0;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] act;
  int          n_checks = 0;
  int          n_fail   = 0;

  gpio_bank_if #(.CH(CH)) bus ();

  gpio_bank #(
    .CH       (CH),
    .WIDTH    (WIDTH),
    .DB_CYCLES(16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus),
    .i_gp   (gp_i),
    .o_gp   (gp_o),
    .o_gp_oe(gp_oe),
    .o_irq  (irq)
  );

  always #5 clk = ~clk;

  // Monitor: pop one expectation per observed output event
  always @(negedge clk) begin
    if ((bus.sel && bus.rd) || chk) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: actual output event, required none queued");
      end else begin
        cur = sb_q.pop_front();
        case (cur.kind)
          0:       act = bus.rdata;
          1:       act = 32'(gp_o);
          2:       act = 32'(gp_oe);
          default: act = {31'd0, irq};
        endcase
        if (act !== cur.exp) begin
          n_fail++;
          $display("FAIL %s: actual 0x%0h required 0x%0h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic [31:0] e, input string nm);
    exp_t t;
    t.kind = k;
    t.exp  = e;
    t.name = nm;
    sb_q.push_back(t);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input int c, input int r, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.wr    = 1'b1;
    bus.wadr  = AW'(c * 8 + r);
    bus.wdata = d;
    cyc(1);
    bus.sel   = 1'b0;
    bus.wr    = 1'b0;
  endtask

  task automatic rd_reg(input int c, input int r, input logic [31:0] e, input string nm);
    push_exp(0, e, nm);
    bus.sel  = 1'b1;
    bus.rd   = 1'b1;
    bus.wadr = AW'(c * 8 + r);
    cyc(1);
    bus.sel  = 1'b0;
    bus.rd   = 1'b0;
  endtask

  task automatic chk_out(input int k, input logic [31:0] e, input string nm);
    push_exp(k, e, nm);
    chk = 1'b1;
    cyc(1);
    chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sel   = 1'b0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.wadr  = '0;
    bus.wdata = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(1);

    // Reset state
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 8; r++) begin
        rd_reg(c, r, 32'h0, $sformatf("reset_ch%0d_reg%0d", c, r));
      end
    end
    chk_out(1, 32'h0, "reset_gp_o");
    chk_out(2, 32'h0, "reset_gp_oe");
    chk_out(3, 32'h0, "reset_irq");

    // Output load, set, clear on ch1
    wr_reg(1, 0, 32'hFFFF_FFA5);
    chk_out(1, 32'h00_A500, "data_load_gp_o");
    wr_reg(1, 1, 32'h0000_00FF);
    chk_out(2, 32'h00_FF00, "oe_gp_oe");
    wr_reg(1, 6, 32'h0000_0002);
    chk_out(1, 32'h00_A700, "set_gp_o");
    wr_reg(1, 7, 32'h0000_0080);
    chk_out(1, 32'h00_2700, "clr_gp_o");
    rd_reg(1, 6, 32'h27, "set_reads_out");
    rd_reg(1, 7, 32'h27, "clr_reads_out");
    rd_reg(1, 1, 32'hFF, "oe_readback");
    bus.wadr = AW'(1 * 8 + 6);
    chk_out(0, 32'h0, "rdata_without_sel");

    // Rising edge on ch0 bit0 with latency and irq
    wr_reg(0, 3, 32'h01);
    wr_reg(0, 2, 32'h01);
    gp_i[0] = 1'b1;
    cyc(Lat - 1);
    rd_reg(0, 5, 32'h00, "status_before_latency");
    rd_reg(0, 5, 32'h01, "status_at_latency");
    chk_out(3, 32'h1, "irq_after_status");
    rd_reg(0, 0, 32'h01, "data_filtered_input");
    wr_reg(0, 5, 32'h01);
    rd_reg(0, 5, 32'h00, "status_w1c");
    chk_out(3, 32'h0, "irq_after_w1c");

    // Falling edge on bit3 coinciding with W1C of bit3
    wr_reg(0, 4, 32'h08);
    gp_i[3] = 1'b1;
    cyc(Lat + 2);
    rd_reg(0, 5, 32'h00, "no_rise_on_bit3");
    gp_i[3] = 1'b0;
    cyc(Lat - 1);
    wr_reg(0, 5, 32'h08);
    rd_reg(0, 5, 32'h08, "set_wins_over_w1c");
    wr_reg(0, 2, 32'h08);
    rd_reg(0, 2, 32'h08, "ie_readback");
    chk_out(3, 32'h1, "irq_from_bit3");

    // Channel 2 works, channel 3 is out of range
    wr_reg(2, 1, 32'h3C);
    chk_out(2, 32'h3C_FF00, "ch2_oe");
    wr_reg(3, 1, 32'hFF);
    wr_reg(3, 0, 32'hFF);
    rd_reg(3, 1, 32'h0, "oor_read_oe");
    rd_reg(3, 6, 32'h0, "oor_read_out");
    chk_out(2, 32'h3C_FF00, "oor_write_oe_ignored");
    chk_out(1, 32'h00_2700, "oor_write_out_ignored");
    rd_reg(0, 1, 32'h0, "oor_ch0_oe_untouched");

    // Asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    chk_out(1, 32'h0, "midreset_gp_o");
    chk_out(2, 32'h0, "midreset_gp_oe");
    chk_out(3, 32'h0, "midreset_irq");
    #2 rst_n = 1'b1;
    cyc(Lat + 2);
    rd_reg(0, 5, 32'h0, "post_reset_status");
    rd_reg(0, 2, 32'h0, "post_reset_ie");
    rd_reg(0, 0, 32'h01, "post_reset_data");

`ifdef GPIO_DEBOUNCE_EN
    // Short glitch is filtered, long pulse is seen at cycle 19
    wr_reg(0, 3, 32'h04);
    gp_i[2] = 1'b1;
    cyc(10);
    gp_i[2] = 1'b0;
    cyc(30);
    rd_reg(0, 5, 32'h00, "glitch_suppressed");
    gp_i[2] = 1'b1;
    cyc(Lat - 1);
    rd_reg(0, 5, 32'h00, "db_before_latency");
    rd_reg(0, 5, 32'h04, "db_at_latency");
    gp_i[2] = 1'b0;
    cyc(2);
`endif

    cyc(2);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
